pcpi_fp_dispatch: RTL
=====================

Name: pcpi_fp_dispatch

Overview:
Sits between the PicoRV32 PCPI port and the floating-point co-processors (FP adder on unit 0, FP multiplier on unit 1). It decodes custom-0 R-type instructions and forwards each one, with registered operands, to exactly one unit. It returns that unit's result to the core as a single-cycle ready/wr pulse. A watchdog completes any instruction the unit never finishes, and a small set of performance counters is exported.

Parameters:
OPCODE, 7'b0001011, custom-0 major opcode accepted
FUNCT7_U0, 7'b0000000, funct7 routed to unit 0 (fpadd)
FUNCT7_U1, 7'b0000001, funct7 routed to unit 1 (fpmul)
TIMEOUT, 256, max cycles in WAIT before watchdog completion (>=4)
TIMEOUT_RD, 32'h7FC00000, result written on watchdog completion (qNaN)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
pcpi_valid  in  1  core request valid
pcpi_insn  in  32  core instruction
pcpi_rs1  in  32  core operand 1
pcpi_rs2  in  32  core operand 2
pcpi_wr  out  1  result write enable to core
pcpi_rd  out  32  result to core
pcpi_wait  out  1  busy indication to core
pcpi_ready  out  1  completion pulse to core
u0_valid, u1_valid  out  1 each  request to unit 0 / unit 1
u_insn  out  32  latched instruction, shared by both units
u_rs1, u_rs2  out  32 each  latched operands, shared by both units
u0_ready, u1_ready  in  1 each  unit completion
u0_wr, u1_wr  in  1 each  unit write enable
u0_rd, u1_rd  in  32 each  unit result
timeout_err  out  1  sticky flag; set by a watchdog completion
op_count  out  32  number of completed dispatches (wraps)
last_latency  out  16  cycles from ISSUE to capture for the last op (saturates at 16'hFFFF)

Behaviour:
- Reset: resetn is synchronous and active-low, clock clk. resetn==0 at a clk edge forces state IDLE. It clears pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, u0_valid, u1_valid, u_insn, u_rs1, u_rs2, timeout_err, op_count, last_latency and the watchdog counter to 0.
- A reset mid-operation abandons the op. Unit valids drop on the same edge and no ready is issued.
- All outputs are registered.
- match = pcpi_valid && insn[6:0]==OPCODE && (insn[31:25]==FUNCT7_U0 || insn[31:25]==FUNCT7_U1).
- On a non-matching insn the block stays IDLE with pcpi_wait=0, leaving the core's illegal-instruction timeout to act.
- States are IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: when match is sampled, latch insn/rs1/rs2 into u_*, record sel (0 for U0, 1 for U1), set pcpi_wait=1 and go to ISSUE.
- ISSUE (1 cycle): assert u{sel}_valid=1, clear the watchdog counter and go to WAIT. The other unit's valid stays 0 at all times.
- WAIT:
  - Watchdog increments each cycle.
  - If u{sel}_ready is sampled 1: capture pcpi_rd<=u{sel}_rd and pcpi_wr<=u{sel}_wr, set u{sel}_valid=0, load last_latency and go to RESP.
  - Else, if the watchdog reaches TIMEOUT: pcpi_rd<=TIMEOUT_RD, pcpi_wr<=1, timeout_err<=1, u{sel}_valid=0, go to RESP.
  - If ready and timeout occur on the same cycle, ready wins and timeout_err is not set.
  - Ready from the non-selected unit is ignored.
- RESP (1 cycle): pcpi_ready=1 and pcpi_wait=0 on the same cycle. op_count increments (wraps from 32'hFFFFFFFF to 0). Go to DRAIN.
- DRAIN: pcpi_ready=0 and pcpi_wr=0; pcpi_rd holds its value. Return to IDLE only when pcpi_valid==0 and u{sel}_ready==0 are both sampled. This absorbs units that hold ready for more than one cycle, so no back-to-back re-issue can happen.
- Latency: a match sampled at edge t gives u_valid high after t+1. A unit ready sampled at edge k gives pcpi_ready high for exactly the cycle after k. With a 1-cycle unit, pcpi_ready rises after t+3.
- last_latency counts the cycles u{sel}_valid was high before capture.
- Only one outstanding op exists at a time. pcpi_valid changes during ISSUE, WAIT or RESP are ignored; the latched operands are used.

Test Plan:
- fpadd path: insn={7'h00,..,7'b0001011}, rs1=32'h3F800000, rs2=32'h40000000. Model unit 0 returns rd=32'h40400000 with wr=1 after 10 cycles. Expect u1_valid never set, pcpi_ready for 1 cycle, pcpi_rd=32'h40400000, pcpi_wr=1, op_count=1, last_latency=10.
- fpmul path: funct7=7'h01, rs1=32'h40000000, rs2=32'h40400000. Unit 1 returns rd=32'h40C00000. Expect routing to unit 1 only and pcpi_rd=32'h40C00000.
- Illegal funct7=7'h05 with pcpi_valid held for 20 cycles: pcpi_wait, pcpi_ready and both unit valids stay 0 throughout.
- Watchdog: unit 0 never readies, TIMEOUT=256. Expect pcpi_ready after 256 WAIT cycles with pcpi_rd=32'h7FC00000, pcpi_wr=1, timeout_err=1. Then a normal op: timeout_err stays 1.
- Sticky ready: unit 0 holds ready for 2 cycles and the core holds valid 1 cycle past ready. Expect exactly one pcpi_ready pulse and one dispatch, then IDLE. A back-to-back second op is accepted only after DRAIN exits.
- Reset mid-WAIT: assert resetn=0 for 1 cycle during WAIT. Expect all outputs 0 on the next edge, no pcpi_ready, and a fresh op afterwards completing normally.

Source files
------------

// File: rtl/pcpi_fp_dispatch_if.sv
// PCPI-to-FP-unit bus bundle.
// Carries the core-side PCPI request/response and the shared request/response
// lines of the two floating-point units (unit 0 = fpadd, unit 1 = fpmul).
//   slave  : the dispatcher (PCPI slave toward the core, requester toward the units)
//   master : the environment (core plus both units)
interface pcpi_fp_dispatch_if;
   // core side
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;
   // unit side
   logic        u0_valid;
   logic        u1_valid;
   logic [31:0] u_insn;
   logic [31:0] u_rs1;
   logic [31:0] u_rs2;
   logic        u0_ready;
   logic        u1_ready;
   logic        u0_wr;
   logic        u1_wr;
   logic [31:0] u0_rd;
   logic [31:0] u1_rd;

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      output u0_valid, u1_valid, u_insn, u_rs1, u_rs2,
      input  u0_ready, u1_ready, u0_wr, u1_wr, u0_rd, u1_rd
   );

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      input  u0_valid, u1_valid, u_insn, u_rs1, u_rs2,
      output u0_ready, u1_ready, u0_wr, u1_wr, u0_rd, u1_rd
   );
endinterface

// File: rtl/pcpi_fp_dispatch.sv
// PCPI dispatcher for the floating-point co-processors.
// Decodes custom-0 R-type instructions, forwards each one with latched operands
// to exactly one unit (funct7 selects fpadd on unit 0 or fpmul on unit 1) and
// returns the unit's result to the core as a one-cycle ready/wr pulse. A
// watchdog completes ops the unit never finishes, writing a quiet NaN.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   bus           PCPI request/response and unit request/response (slave view)
//   timeout_err   sticky, set by any watchdog completion
//   op_count      completed dispatches, wraps
//   last_latency  cycles the unit valid was high before the last capture (saturating)
// All outputs are registered.
module pcpi_fp_dispatch #(
   parameter logic [6:0]  OPCODE     = 7'b0001011,
   parameter logic [6:0]  FUNCT7_U0  = 7'b0000000,
   parameter logic [6:0]  FUNCT7_U1  = 7'b0000001,
   parameter int unsigned TIMEOUT    = 256,
   parameter logic [31:0] TIMEOUT_RD = 32'h7FC00000
) (
   input  logic               clk,
   input  logic               resetn,
   pcpi_fp_dispatch_if.slave  bus,
   output logic               timeout_err,
   output logic [31:0]        op_count,
   output logic [15:0]        last_latency
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic            sel_q, sel_d;
   logic [WD_W-1:0] wdog_q, wdog_d;

   logic        pcpi_wr_q, pcpi_wr_d;
   logic [31:0] pcpi_rd_q, pcpi_rd_d;
   logic        pcpi_wait_q, pcpi_wait_d;
   logic        pcpi_ready_q, pcpi_ready_d;
   logic        u0_valid_q, u0_valid_d;
   logic        u1_valid_q, u1_valid_d;
   logic [31:0] u_insn_q, u_insn_d;
   logic [31:0] u_rs1_q, u_rs1_d;
   logic [31:0] u_rs2_q, u_rs2_d;
   logic        timeout_err_q, timeout_err_d;
   logic [31:0] op_count_q, op_count_d;
   logic [15:0] last_latency_q, last_latency_d;

   logic        match;
   logic [6:0]  funct7;
   logic        sel_ready;
   logic        sel_wr;
   logic [31:0] sel_rd;
   logic [31:0] lat_full;
   logic [15:0] lat_sat;

   // Decode of the incoming request.
   assign funct7 = bus.pcpi_insn[31:25];
   assign match  = bus.pcpi_valid && (bus.pcpi_insn[6:0] == OPCODE) &&
                   ((funct7 == FUNCT7_U0) || (funct7 == FUNCT7_U1));

   // Response of the selected unit; the other unit's response is never looked at.
   assign sel_ready = sel_q ? bus.u1_ready : bus.u0_ready;
   assign sel_wr    = sel_q ? bus.u1_wr    : bus.u0_wr;
   assign sel_rd    = sel_q ? bus.u1_rd    : bus.u0_rd;

   // The watchdog counts completed WAIT cycles, so the valid-high time at capture is one more.
   assign lat_full = 32'(wdog_q) + 32'd1;
   assign lat_sat  = (lat_full > 32'h0000_FFFF) ? 16'hFFFF : lat_full[15:0];

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         sel_q          <= 1'b0;
         wdog_q         <= '0;
         pcpi_wr_q      <= 1'b0;
         pcpi_rd_q      <= 32'd0;
         pcpi_wait_q    <= 1'b0;
         pcpi_ready_q   <= 1'b0;
         u0_valid_q     <= 1'b0;
         u1_valid_q     <= 1'b0;
         u_insn_q       <= 32'd0;
         u_rs1_q        <= 32'd0;
         u_rs2_q        <= 32'd0;
         timeout_err_q  <= 1'b0;
         op_count_q     <= 32'd0;
         last_latency_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         wdog_q         <= wdog_d;
         pcpi_wr_q      <= pcpi_wr_d;
         pcpi_rd_q      <= pcpi_rd_d;
         pcpi_wait_q    <= pcpi_wait_d;
         pcpi_ready_q   <= pcpi_ready_d;
         u0_valid_q     <= u0_valid_d;
         u1_valid_q     <= u1_valid_d;
         u_insn_q       <= u_insn_d;
         u_rs1_q        <= u_rs1_d;
         u_rs2_q        <= u_rs2_d;
         timeout_err_q  <= timeout_err_d;
         op_count_q     <= op_count_d;
         last_latency_q <= last_latency_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      wdog_d         = wdog_q;
      pcpi_wr_d      = pcpi_wr_q;
      pcpi_rd_d      = pcpi_rd_q;
      pcpi_wait_d    = pcpi_wait_q;
      pcpi_ready_d   = pcpi_ready_q;
      u0_valid_d     = u0_valid_q;
      u1_valid_d     = u1_valid_q;
      u_insn_d       = u_insn_q;
      u_rs1_d        = u_rs1_q;
      u_rs2_d        = u_rs2_q;
      timeout_err_d  = timeout_err_q;
      op_count_d     = op_count_q;
      last_latency_d = last_latency_q;

      case (state_q)
         S_IDLE: begin
            if (match) begin
               u_insn_d    = bus.pcpi_insn;
               u_rs1_d     = bus.pcpi_rs1;
               u_rs2_d     = bus.pcpi_rs2;
               // unit 0 wins if both funct7 parameters are set equal
               sel_d       = (funct7 != FUNCT7_U0);
               pcpi_wait_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            u0_valid_d = !sel_q;
            u1_valid_d = sel_q;
            wdog_d     = '0;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            // ready takes priority over an expiring watchdog on the same cycle
            if (sel_ready) begin
               pcpi_rd_d      = sel_rd;
               pcpi_wr_d      = sel_wr;
               last_latency_d = lat_sat;
               u0_valid_d     = 1'b0;
               u1_valid_d     = 1'b0;
               pcpi_ready_d   = 1'b1;
               pcpi_wait_d    = 1'b0;
               op_count_d     = op_count_q + 32'd1;
               state_d        = S_RESP;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               pcpi_rd_d      = TIMEOUT_RD;
               pcpi_wr_d      = 1'b1;
               timeout_err_d  = 1'b1;
               u0_valid_d     = 1'b0;
               u1_valid_d     = 1'b0;
               pcpi_ready_d   = 1'b1;
               pcpi_wait_d    = 1'b0;
               op_count_d     = op_count_q + 32'd1;
               state_d        = S_RESP;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end

         S_RESP: begin
            pcpi_ready_d = 1'b0;
            pcpi_wr_d    = 1'b0;
            state_d      = S_DRAIN;
         end

         S_DRAIN: begin
            // hold off until the core and the unit have both let go
            if (!bus.pcpi_valid && !sel_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.pcpi_wr    = pcpi_wr_q;
   assign bus.pcpi_rd    = pcpi_rd_q;
   assign bus.pcpi_wait  = pcpi_wait_q;
   assign bus.pcpi_ready = pcpi_ready_q;
   assign bus.u0_valid   = u0_valid_q;
   assign bus.u1_valid   = u1_valid_q;
   assign bus.u_insn     = u_insn_q;
   assign bus.u_rs1      = u_rs1_q;
   assign bus.u_rs2      = u_rs2_q;
   assign timeout_err    = timeout_err_q;
   assign op_count       = op_count_q;
   assign last_latency   = last_latency_q;

endmodule
